// File: rtl/spmm_pkg.sv
// Shared types for the indexed shift buffer: operation codes, FSM states and per-cell select.
package spmm_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_FLUSH  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_LEFT  = 3'd1,
        SEL_RIGHT = 3'd2,
        SEL_DATA  = 3'd3,
        SEL_ZERO  = 3'd4
    } sel_e;

endpackage

// File: rtl/indexed_shift_cell.sv
// One array position: picks its next value from hold, neighbours, op_data or zero
// using the broadcast control decode and its own position.
module indexed_shift_cell
    import spmm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CW     = 5,
    parameter int unsigned POS    = 0
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] left,
    input  logic [DATA_W-1:0] right,
    input  logic [DATA_W-1:0] data,
    input  logic              ins_en,
    input  logic              del_en,
    input  logic              drain_en,
    input  logic [CW-1:0]     idx,
    input  logic [CW-1:0]     count,
    input  logic [CW-1:0]     cnt_m1,
    output logic [DATA_W-1:0] nxt
);

    localparam logic [CW-1:0] P = CW'(POS);

    sel_e sel;

    // Drain is a delete at position 0; the last valid slot is cleared on any removal.
    always_comb begin
        sel = SEL_HOLD;
        if (ins_en) begin
            if (P == idx)
                sel = SEL_DATA;
            else if (P > idx && P <= count)
                sel = SEL_LEFT;
        end else if (del_en || drain_en) begin
            if (P == cnt_m1)
                sel = SEL_ZERO;
            else if ((drain_en || P >= idx) && P < count)
                sel = SEL_RIGHT;
        end
    end

    always_comb begin
        nxt = cur;
        case (sel)
            SEL_LEFT:  nxt = left;
            SEL_RIGHT: nxt = right;
            SEL_DATA:  nxt = data;
            SEL_ZERO:  nxt = '0;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/indexed_shift_buf.sv
// Register array with indexed insert/delete and a flush drain stream.
module indexed_shift_buf
    import spmm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [1:0]              op_code,
    input  logic [IDX_W-1:0]        op_idx,
    input  logic [DATA_W-1:0]       op_data,
    output logic [DATA_W*DEPTH-1:0] arr_out,
    output logic [IDX_W:0]          count_out,
    output logic                    full,
    output logic                    empty,
    output logic                    err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data
);

    localparam int unsigned CW = IDX_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e            state;
    state_e            state_d;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_d;
    logic [DATA_W-1:0] arr_q [DEPTH];
    logic [DATA_W-1:0] arr_d [DEPTH];

    op_e           code;
    logic          accept;
    logic          ins_req;
    logic          del_req;
    logic          ins_en;
    logic          del_en;
    logic          drain_en;
    logic          flush_go;
    logic          err_d;
    logic [CW-1:0] idx_ext;
    logic [CW-1:0] idx_c;
    logic [CW-1:0] cnt_m1;

    // Control decode shared by every cell.
    always_comb begin
        code     = op_e'(op_code);
        idx_ext  = CW'(op_idx);
        accept   = op_valid && (state == ST_IDLE);
        ins_req  = accept && (code == OP_INSERT);
        del_req  = accept && (code == OP_DELETE);
        ins_en   = ins_req && (count != DEPTH_C);
        del_en   = del_req && (idx_ext < count);
        err_d    = (ins_req && !ins_en) || (del_req && !del_en);
        flush_go = accept && (code == OP_FLUSH) && (count != '0);
        drain_en = (state == ST_FLUSH) && out_ready;
        idx_c    = (ins_en && idx_ext > count) ? count : idx_ext;
        cnt_m1   = count - CW'(1);
        count_d  = count + CW'(ins_en) - CW'(del_en) - CW'(drain_en);
        state_d  = state;
        if (state == ST_IDLE && flush_go)
            state_d = ST_FLUSH;
        else if (state == ST_FLUSH && drain_en && count == CW'(1))
            state_d = ST_IDLE;
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_cell
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        if (i == 0) begin : g_l0
            assign left = '0;
        end else begin : g_l
            assign left = arr_q[i-1];
        end
        if (i == int'(DEPTH) - 1) begin : g_rn
            assign right = '0;
        end else begin : g_r
            assign right = arr_q[i+1];
        end

        indexed_shift_cell #(
            .DATA_W (DATA_W),
            .CW     (CW),
            .POS    (i)
        ) u_cell (
            .cur      (arr_q[i]),
            .left     (left),
            .right    (right),
            .data     (op_data),
            .ins_en   (ins_en),
            .del_en   (del_en),
            .drain_en (drain_en),
            .idx      (idx_c),
            .count    (count),
            .cnt_m1   (cnt_m1),
            .nxt      (arr_d[i])
        );

        assign arr_out[i*DATA_W +: DATA_W] = arr_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            op_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++)
                arr_q[i] <= '0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            err       <= err_d;
            full      <= (count_d == DEPTH_C);
            empty     <= (count_d == '0);
            op_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_FLUSH);
            for (int i = 0; i < int'(DEPTH); i++)
                arr_q[i] <= arr_d[i];
        end
    end

    assign count_out = count;
    assign out_data  = arr_q[0];

endmodule

// File: tb/tb_indexed_shift_buf.sv
// Directed table-driven bench for indexed_shift_buf (DATA_W=32, DEPTH=16).
module tb_indexed_shift_buf;

    localparam int DW = 32;
    localparam int DP = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic           op_ready;
    logic [1:0]     op_code;
    logic [3:0]     op_idx;
    logic [DW-1:0]  op_data;
    logic [DW*DP-1:0] arr_out;
    logic [4:0]     count_out;
    logic           full;
    logic           empty;
    logic           err;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    indexed_shift_buf #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_idx    (op_idx),
        .op_data   (op_data),
        .arr_out   (arr_out),
        .count_out (count_out),
        .full      (full),
        .empty     (empty),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    localparam logic [1:0] NOP = 2'b00, INS = 2'b01, DEL = 2'b10, FLU = 2'b11;

    typedef struct {
        logic        r;
        logic        v;
        logic [1:0]  code;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [4:0]  cnt;
        logic        er;
        logic [31:0] e0, e1, e2;
        logic        rdy, ov, emp, ful;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic r, logic v, logic [1:0] code, logic [3:0] idx,
                                logic [31:0] data, logic [4:0] cnt, logic er,
                                logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
        vec_t t;
        t.r = r; t.v = v; t.code = code; t.idx = idx; t.data = data;
        t.cnt = cnt; t.er = er; t.e0 = e0; t.e1 = e1; t.e2 = e2;
        t.rdy = 1'b1; t.ov = 1'b0; t.emp = (cnt == 0); t.ful = (cnt == 5'(DP));
        return t;
    endfunction

    function automatic logic [31:0] ent(int i);
        return arr_out[i*DW +: DW];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and sample 1 time unit after the rising edge.
    task automatic step(logic r, logic v, logic [1:0] code, logic [3:0] idx,
                        logic [31:0] data, logic ordy);
        rst = r; op_valid = v; op_code = code; op_idx = idx; op_data = data; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    logic [DW*DP-1:0] snap;
    logic [31:0]      got [$];

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = NOP; op_idx = '0; op_data = '0; out_ready = 1'b0;

        tbl[0]  = mk(1, 0, NOP, 0, 0,     0, 0, 0,    0,   0);
        tbl[1]  = mk(0, 1, INS, 0, 32'hA, 1, 0, 32'hA, 0,   0);
        tbl[2]  = mk(0, 1, INS, 0, 32'hB, 2, 0, 32'hB, 32'hA, 0);
        tbl[3]  = mk(0, 1, INS, 1, 32'hC, 3, 0, 32'hB, 32'hC, 32'hA);
        tbl[4]  = mk(0, 1, NOP, 2, 32'hF, 3, 0, 32'hB, 32'hC, 32'hA);
        tbl[5]  = mk(0, 1, DEL, 1, 0,     2, 0, 32'hB, 32'hA, 0);
        tbl[6]  = mk(0, 1, DEL, 5, 0,     2, 1, 32'hB, 32'hA, 0);
        tbl[7]  = mk(0, 1, NOP, 0, 0,     2, 0, 32'hB, 32'hA, 0);
        tbl[8]  = mk(0, 1, INS, 9, 32'h7, 3, 0, 32'hB, 32'hA, 32'h7);
        tbl[9]  = mk(0, 0, INS, 0, 32'h55, 3, 0, 32'hB, 32'hA, 32'h7);
        tbl[10] = mk(0, 1, DEL, 0, 0,     2, 0, 32'hA, 32'h7, 0);
        tbl[11] = mk(0, 1, DEL, 1, 0,     1, 0, 32'hA, 0,   0);
        tbl[12] = mk(0, 1, DEL, 0, 0,     0, 0, 0,    0,   0);
        tbl[13] = mk(0, 1, DEL, 0, 0,     0, 1, 0,    0,   0);
        tbl[14] = mk(0, 1, FLU, 0, 0,     0, 0, 0,    0,   0);

        @(posedge clk); #1;
        for (int k = 0; k < 15; k++) begin
            step(tbl[k].r, tbl[k].v, tbl[k].code, tbl[k].idx, tbl[k].data, 1'b0);
            chk($sformatf("v%0d count", k), 64'(count_out), 64'(tbl[k].cnt));
            chk($sformatf("v%0d err", k), 64'(err), 64'(tbl[k].er));
            chk($sformatf("v%0d e0", k), 64'(ent(0)), 64'(tbl[k].e0));
            chk($sformatf("v%0d e1", k), 64'(ent(1)), 64'(tbl[k].e1));
            chk($sformatf("v%0d e2", k), 64'(ent(2)), 64'(tbl[k].e2));
            chk($sformatf("v%0d upper", k), 64'(arr_out[DW*DP-1:3*DW] != '0), 64'(0));
            chk($sformatf("v%0d op_ready", k), 64'(op_ready), 64'(tbl[k].rdy));
            chk($sformatf("v%0d out_valid", k), 64'(out_valid), 64'(tbl[k].ov));
            chk($sformatf("v%0d empty", k), 64'(empty), 64'(tbl[k].emp));
            chk($sformatf("v%0d full", k), 64'(full), 64'(tbl[k].ful));
        end

        // Fill to capacity: inserting 1..16 at 0 leaves 16 at position 0 down to 1 at 15.
        step(1, 0, NOP, 0, 0, 0);
        for (int v = 1; v <= DP; v++) step(0, 1, INS, 0, 32'(v), 0);
        chk("fill full", 64'(full), 64'(1));
        chk("fill count", 64'(count_out), 64'(DP));
        for (int i = 0; i < DP; i++) snap[i*DW +: DW] = 32'(DP - i);
        chk("fill array", 64'(arr_out == snap), 64'(1));
        step(0, 1, INS, 3, 32'h99, 0);
        chk("ovf err", 64'(err), 64'(1));
        chk("ovf array", 64'(arr_out == snap), 64'(1));
        chk("ovf count", 64'(count_out), 64'(DP));
        step(0, 1, DEL, 15, 0, 0);
        chk("del last count", 64'(count_out), 64'(DP - 1));
        chk("del last e15", 64'(ent(15)), 64'(0));
        chk("del last e14", 64'(ent(14)), 64'(2));
        chk("del last full", 64'(full), 64'(0));

        // Flush drain of [5,6,7] with out_ready 1,0,1,1; an INSERT held on op_valid must be ignored.
        step(1, 0, NOP, 0, 0, 0);
        step(0, 1, INS, 0, 32'h5, 0);
        step(0, 1, INS, 1, 32'h6, 0);
        step(0, 1, INS, 2, 32'h7, 0);
        step(0, 1, FLU, 0, 0, 0);
        chk("flush enter valid", 64'(out_valid), 64'(1));
        chk("flush enter ready", 64'(op_ready), 64'(0));
        chk("flush head", 64'(out_data), 64'(5));
        begin
            logic rdy_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
            for (int b = 0; b < 4; b++) begin
                if (out_valid && rdy_seq[b]) got.push_back(out_data);
                step(0, 1, INS, 0, 32'hEE, rdy_seq[b]);
                if (b == 1) chk("flush hold data", 64'(out_data), 64'(6));
                if (b < 3) chk($sformatf("flush b%0d ready", b), 64'(op_ready), 64'(0));
            end
        end
        chk("flush beats", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            chk("flush d0", 64'(got[0]), 64'(5));
            chk("flush d1", 64'(got[1]), 64'(6));
            chk("flush d2", 64'(got[2]), 64'(7));
        end
        chk("flush done valid", 64'(out_valid), 64'(0));
        chk("flush done ready", 64'(op_ready), 64'(1));
        chk("flush done empty", 64'(empty), 64'(1));
        chk("flush done count", 64'(count_out), 64'(0));

        // Reset mid-drain discards the remaining entries.
        step(0, 1, INS, 0, 32'h5, 0);
        step(0, 1, INS, 1, 32'h6, 0);
        step(0, 1, INS, 2, 32'h7, 0);
        step(0, 1, FLU, 0, 0, 0);
        step(0, 0, NOP, 0, 0, 1);
        chk("abort one beat count", 64'(count_out), 64'(2));
        chk("abort one beat data", 64'(out_data), 64'(6));
        step(1, 1, INS, 0, 32'h9, 1);
        chk("abort count", 64'(count_out), 64'(0));
        chk("abort valid", 64'(out_valid), 64'(0));
        chk("abort ready", 64'(op_ready), 64'(1));
        chk("abort array", 64'(arr_out == '0), 64'(1));
        step(0, 0, NOP, 0, 0, 0);
        chk("abort idle empty", 64'(empty), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
